// File: rtl/can_bit_destuffer.sv
// CAN receive-side bit destuffer: strips stuff bits, flags stuff errors and
// tracks bus idle / start-of-frame. Every output is registered (one-cycle latency).
module can_bit_destuffer #(
  parameter int STUFF_LEN = 5,
  parameter int IDLE_LEN  = 11
) (
  input  logic clk,
  input  logic reset,
  input  logic samplePoint,
  input  logic canRX,
  input  logic destuffEn,
  input  logic clearErr,
  output logic bitValid,
  output logic bitOut,
  output logic isStuff,
  output logic stuffError,
  output logic busIdle,
  output logic sofDetect
);

  localparam int CW = $clog2(STUFF_LEN + 1);
  localparam int IW = $clog2(IDLE_LEN + 1);
  localparam logic [CW-1:0] RUN_MAX  = CW'(STUFF_LEN);
  localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_LEN);

  typedef enum logic [1:0] {
    NORMAL       = 2'd0,
    EXPECT_STUFF = 2'd1,
    ERROR        = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] runCnt_q, runCnt_d;
  logic          lastBit_q, lastBit_d;
  logic [IW-1:0] idleCnt_q, idleCnt_d;
  logic          bitValid_q, bitValid_d;
  logic          bitOut_q, bitOut_d;
  logic          isStuff_q, isStuff_d;
  logic          stuffError_q, stuffError_d;
  logic          busIdle_q, busIdle_d;
  logic          sofDetect_q, sofDetect_d;

  always_comb begin
    state_d      = state_q;
    runCnt_d     = runCnt_q;
    lastBit_d    = lastBit_q;
    idleCnt_d    = idleCnt_q;
    bitValid_d   = 1'b0;
    bitOut_d     = bitOut_q;
    isStuff_d    = 1'b0;
    stuffError_d = stuffError_q;
    sofDetect_d  = 1'b0;

    // clearErr beats a coincident strobe: the sample is dropped entirely
    if (clearErr) begin
      state_d      = NORMAL;
      runCnt_d     = '0;
      stuffError_d = 1'b0;
    end else if (samplePoint) begin
      if (canRX) begin
        if (idleCnt_q != IDLE_MAX) idleCnt_d = idleCnt_q + 1'b1;
      end else begin
        idleCnt_d   = '0;
        sofDetect_d = (idleCnt_q == IDLE_MAX);
      end

      unique case (state_q)
        NORMAL: begin
          bitValid_d = 1'b1;
          bitOut_d   = canRX;
          if (!destuffEn) begin
            runCnt_d = '0;
          end else begin
            if ((runCnt_q != '0) && (canRX == lastBit_q)) runCnt_d = runCnt_q + 1'b1;
            else runCnt_d = CW'(1);
            lastBit_d = canRX;
            if (runCnt_d == RUN_MAX) state_d = EXPECT_STUFF;
          end
        end
        // the pending stuff bit is consumed even after destuffEn has dropped
        EXPECT_STUFF: begin
          if (canRX != lastBit_q) begin
            isStuff_d = 1'b1;
            runCnt_d  = CW'(1);
            lastBit_d = canRX;
            state_d   = NORMAL;
          end else begin
            stuffError_d = 1'b1;
            state_d      = ERROR;
          end
        end
        ERROR: begin
        end
        default: state_d = NORMAL;
      endcase
    end

    busIdle_d = (idleCnt_d == IDLE_MAX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= NORMAL;
      runCnt_q     <= '0;
      lastBit_q    <= 1'b1;
      idleCnt_q    <= '0;
      bitValid_q   <= 1'b0;
      bitOut_q     <= 1'b1;
      isStuff_q    <= 1'b0;
      stuffError_q <= 1'b0;
      busIdle_q    <= 1'b0;
      sofDetect_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      runCnt_q     <= runCnt_d;
      lastBit_q    <= lastBit_d;
      idleCnt_q    <= idleCnt_d;
      bitValid_q   <= bitValid_d;
      bitOut_q     <= bitOut_d;
      isStuff_q    <= isStuff_d;
      stuffError_q <= stuffError_d;
      busIdle_q    <= busIdle_d;
      sofDetect_q  <= sofDetect_d;
    end
  end

  assign bitValid   = bitValid_q;
  assign bitOut     = bitOut_q;
  assign isStuff    = isStuff_q;
  assign stuffError = stuffError_q;
  assign busIdle    = busIdle_q;
  assign sofDetect  = sofDetect_q;

endmodule

// File: doc/can_bit_destuffer.md
CAN_BIT_DESTUFFER -- requirements
Module: can_bit_destuffer

Interface
REQ-001 Parameter STUFF_LEN, default 5: number of consecutive equal bits after which a stuff bit is expected.
REQ-002 Parameter IDLE_LEN, default 11: number of consecutive recessive samples that declare bus idle.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset; highest priority.
REQ-005 samplePoint  input  1  one-clk strobe; canRX is valid and consumed only in cycles where it is high.
REQ-006 canRX  input  1  sampled bus level; 0 = dominant, 1 = recessive.
REQ-007 destuffEn  input  1  high while the frame controller is in the stuffed region (SOF through CRC).
REQ-008 clearErr  input  1  one-clk pulse; clears the stuff error and restarts destuffing.
REQ-009 bitValid  output  1  one-clk pulse; bitOut carries a destuffed data bit.
REQ-010 bitOut  output  1  destuffed data bit; held between pulses.
REQ-011 isStuff  output  1  one-clk pulse; the consumed sample was a stuff bit (feeds CRC stage to skip it).
REQ-012 stuffError  output  1  sticky; STUFF_LEN+1 equal bits were seen in the stuffed region.
REQ-013 busIdle  output  1  high while at least IDLE_LEN consecutive recessive samples have been seen.
REQ-014 sofDetect  output  1  one-clk pulse on the first dominant sample following busIdle.

Function
REQ-015 All outputs SHALL be registered; every response to a strobe appears in the cycle after the samplePoint cycle, a fixed one-cycle latency.
REQ-016 bitValid, isStuff and sofDetect SHALL be low in every cycle not directly following a consumed strobe.
REQ-017 The state machine SHALL have the states NORMAL, EXPECT_STUFF and ERROR; state changes occur only on strobes, clearErr or reset.
REQ-018 The run counter SHALL be ceil(log2(STUFF_LEN+1)) bits wide, SHALL never exceed STUFF_LEN, and SHALL be tracked together with lastBit.
REQ-019 NORMAL, destuffEn=0: the bit passes through (bitValid=1, bitOut=canRX), runCnt=0, the state is unchanged and there is no stuff checking.
REQ-020 NORMAL, destuffEn=1: if runCnt>0 and canRX==lastBit then runCnt+1, else runCnt=1; lastBit=canRX; bitValid=1, bitOut=canRX.
REQ-021 NORMAL: when the updated runCnt equals STUFF_LEN, the state SHALL become EXPECT_STUFF; the bit that completes the run is still delivered.
REQ-022 EXPECT_STUFF with canRX!=lastBit: isStuff=1, bitValid=0, runCnt=1, lastBit=canRX, next state NORMAL; the stuff bit counts as bit 1 of the new run.
REQ-023 EXPECT_STUFF with canRX==lastBit: stuffError=1, bitValid=0, isStuff=0, next state ERROR.
REQ-024 EXPECT_STUFF SHALL consume the pending stuff bit regardless of destuffEn (stuff bit after the last CRC bit).
REQ-025 ERROR: strobes SHALL produce no bitValid and no isStuff; stuffError SHALL hold until clearErr.
REQ-026 A clearErr in any state SHALL set stuffError=0, runCnt=0, state NORMAL; if a strobe arrives in the same cycle, clearErr wins and the strobe is dropped.
REQ-027 The idle counter SHALL be independent of the state machine: a recessive strobe increments it, saturating at IDLE_LEN; a dominant strobe clears it to 0.
REQ-028 busIdle SHALL equal (idleCnt==IDLE_LEN); sofDetect SHALL pulse when a dominant strobe arrives while busIdle=1, and busIdle SHALL drop in that same output cycle.
REQ-029 sofDetect SHALL NOT depend on destuffEn or on the state machine state.

Reset
REQ-030 When reset is high at a clk edge: state NORMAL, runCnt=0, lastBit=1, idleCnt=0, and all outputs 0 (bitOut=1).
REQ-031 Reset during EXPECT_STUFF or ERROR SHALL discard the pending stuff expectation and the error without producing any pulse.
REQ-032 A strobe coincident with reset SHALL be ignored.

Verification
REQ-033 destuffEn=1, bits 0,0,0,0,0,1,0 -> five bitValid with bitOut=0, one isStuff, then bitValid bitOut=0; stuffError stays 0.
REQ-034 destuffEn=1, bits 1 x6 -> five bitValid, then stuffError=1; further strobes give no bitValid; clearErr -> stuffError=0 and the next strobe gives bitValid.
REQ-035 destuffEn=1, five 0s, then destuffEn=0 and canRX=1 -> isStuff=1, no bitValid for that sample; the next strobe passes through.
REQ-036 Eleven recessive strobes, then one dominant -> busIdle rises after strobe 11; sofDetect pulses once on the dominant strobe and busIdle falls in the same cycle.
REQ-037 Reset asserted while in EXPECT_STUFF, plus clearErr coincident with a strobe -> all outputs 0 after reset; the dropped strobe produces no pulse.
